// File: rtl/sd_data_master.sv
// rtl/sd_data_master.sv - SD data-path sequencer: start handshake, transfer supervision, sticky data status.
// Optional TX underrun detection is enabled by defining SD_TX_UNDERRUN_CHECK_EN.
module sd_data_master #(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 start_tx_i,
  input  logic                 start_rx_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 d_write_o,
  output logic                 d_read_o,
  input  logic                 tx_fifo_rd_en_i,
  input  logic                 tx_fifo_empty_i,
  input  logic                 rx_fifo_wr_en_i,
  input  logic                 rx_fifo_full_i,
  input  logic                 xfr_complete_i,
  input  logic                 crc_ok_i,
  output logic [4:0]           int_status_o,
  input  logic                 int_status_rst_i
);

  localparam logic [4:0] INT_CC    = 5'b00001;
  localparam logic [4:0] INT_EI    = 5'b00010;
  localparam logic [4:0] INT_CTE   = 5'b00100;
  localparam logic [4:0] INT_CCRCE = 5'b01000;
  localparam logic [4:0] INT_CFE   = 5'b10000;

  typedef enum logic [1:0] {
    IDLE,
    START_TX,
    START_RX,
    DATA_TRANSFER
  } state_t;

  state_t               state;
  logic                 tx_cycle;
  logic                 trans_done;
  logic                 busy_seen;
  logic [TIMEOUT_W-1:0] timeout_cnt;

  logic                 evaluate;
  logic                 underrun;
  logic                 fifo_err;
  logic                 timeout_hit;
  logic                 done_hit;
  logic [4:0]           status_set;

`ifdef SD_TX_UNDERRUN_CHECK_EN
  assign underrun = tx_cycle && tx_fifo_rd_en_i && tx_fifo_empty_i;
`else
  assign underrun = 1'b0;
`endif

  // Events are only judged once per transfer; trans_done freezes them until IDLE.
  assign evaluate    = (state == DATA_TRANSFER) && !trans_done;
  assign fifo_err    = evaluate && ((!tx_cycle && rx_fifo_full_i) || underrun);
  assign timeout_hit = evaluate && !fifo_err && (timeout_i != '0) && (timeout_cnt == timeout_i);
  assign done_hit    = evaluate && !fifo_err && !timeout_hit && busy_seen && xfr_complete_i;

  always_comb begin
    status_set = '0;
    if (fifo_err) begin
      status_set = INT_CFE | INT_EI;
    end else if (timeout_hit) begin
      status_set = INT_CTE | INT_EI;
    end else if (done_hit) begin
      status_set = crc_ok_i ? INT_CC : (INT_EI | INT_CCRCE);
    end
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state        <= IDLE;
      tx_cycle     <= 1'b0;
      trans_done   <= 1'b0;
      busy_seen    <= 1'b0;
      timeout_cnt  <= '0;
      d_write_o    <= 1'b0;
      d_read_o     <= 1'b0;
      int_status_o <= '0;
    end else begin
      // A status event in the same cycle as the clear request survives.
      int_status_o <= (int_status_rst_i ? 5'b00000 : int_status_o) | status_set;

      case (state)
        IDLE: begin
          tx_cycle    <= 1'b0;
          trans_done  <= 1'b0;
          busy_seen   <= 1'b0;
          timeout_cnt <= '0;
          d_write_o   <= 1'b0;
          d_read_o    <= 1'b0;
          if (start_tx_i) begin
            state <= START_TX;
          end else if (start_rx_i) begin
            state <= START_RX;
          end
        end

        START_TX: begin
          tx_cycle <= 1'b1;
          if (!tx_fifo_empty_i && xfr_complete_i) begin
            d_write_o <= 1'b1;
            state     <= DATA_TRANSFER;
          end
        end

        START_RX: begin
          if (xfr_complete_i) begin
            d_read_o <= 1'b1;
            state    <= DATA_TRANSFER;
          end
        end

        DATA_TRANSFER: begin
          if (trans_done) begin
            // Stop outputs are held through this cycle so an abort lasts two cycles.
            state <= IDLE;
          end else begin
            if (!xfr_complete_i) begin
              busy_seen <= 1'b1;
            end
            if ((timeout_i == '0) || tx_fifo_rd_en_i || rx_fifo_wr_en_i) begin
              timeout_cnt <= '0;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
            if (fifo_err || timeout_hit) begin
              d_write_o  <= 1'b1;
              d_read_o   <= 1'b1;
              trans_done <= 1'b1;
            end else begin
              d_write_o <= 1'b0;
              d_read_o  <= 1'b0;
              if (done_hit) begin
                trans_done <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_data_master.sv
// tb/tb_sd_data_master.sv - directed self-checking bench for sd_data_master.
module tb_sd_data_master;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic        start_tx_i;
  logic        start_rx_i;
  logic [23:0] timeout_i;
  logic        d_write_o;
  logic        d_read_o;
  logic        tx_fifo_rd_en_i;
  logic        tx_fifo_empty_i;
  logic        rx_fifo_wr_en_i;
  logic        rx_fifo_full_i;
  logic        xfr_complete_i;
  logic        crc_ok_i;
  logic [4:0]  int_status_o;
  logic        int_status_rst_i;

  int vectors = 0;
  int miscompares = 0;

  sd_data_master #(.TIMEOUT_W(24)) dut (
    .sd_clk           (sd_clk),
    .rst              (rst),
    .start_tx_i       (start_tx_i),
    .start_rx_i       (start_rx_i),
    .timeout_i        (timeout_i),
    .d_write_o        (d_write_o),
    .d_read_o         (d_read_o),
    .tx_fifo_rd_en_i  (tx_fifo_rd_en_i),
    .tx_fifo_empty_i  (tx_fifo_empty_i),
    .rx_fifo_wr_en_i  (rx_fifo_wr_en_i),
    .rx_fifo_full_i   (rx_fifo_full_i),
    .xfr_complete_i   (xfr_complete_i),
    .crc_ok_i         (crc_ok_i),
    .int_status_o     (int_status_o),
    .int_status_rst_i (int_status_rst_i)
  );

  always #5 sd_clk = ~sd_clk;

  task automatic tick;
    @(posedge sd_clk);
    #1;
  endtask

  task automatic clear_status(input string name);
    int_status_rst_i = 1'b1;
    tick();
    int_status_rst_i = 1'b0;
    vectors++;
    if (int_status_o !== 5'h00) begin
      miscompares++;
      $display("FAIL %s_status_clear: got 0x%02h expected 0x00", name, int_status_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_tx_i = 0; start_rx_i = 0; timeout_i = 24'd100;
    tx_fifo_rd_en_i = 0; tx_fifo_empty_i = 1; rx_fifo_wr_en_i = 0; rx_fifo_full_i = 0;
    xfr_complete_i = 1; crc_ok_i = 0; int_status_rst_i = 0;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if ({d_write_o, d_read_o, int_status_o, dut.tx_cycle, dut.trans_done} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_state: got wr=%b rd=%b st=0x%02h txc=%b td=%b expected all 0",
               d_write_o, d_read_o, int_status_o, dut.tx_cycle, dut.trans_done);
    end
  endtask

  // Full handshake of one transfer ending in normal completion.
  task automatic run_xfer(input bit is_tx, input bit crc, input int busy_len, input bit clr_at_done,
                          input bit clear_after, input logic [4:0] exp_status, input string name);
    int n;
    bit stray;
    logic pulse, other;
    tx_fifo_empty_i = 1'b1;
    xfr_complete_i  = 1'b1;
    if (is_tx) start_tx_i = 1'b1; else start_rx_i = 1'b1;
    tick();
    start_tx_i = 1'b0; start_rx_i = 1'b0;
    if (is_tx) begin
      tick(); tick(); tick();
      vectors++;
      if (dut.tx_cycle !== 1'b1 || d_write_o !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_wait_empty: got txc=%b wr=%b expected txc=1 wr=0", name, dut.tx_cycle, d_write_o);
      end
      tx_fifo_empty_i = 1'b0;
    end
    n = 0;
    while (!(is_tx ? d_write_o : d_read_o) && n < 10) begin
      tick();
      n++;
    end
    pulse = is_tx ? d_write_o : d_read_o;
    other = is_tx ? d_read_o : d_write_o;
    vectors++;
    if (pulse !== 1'b1 || other !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_start_pulse: got pulse=%b other=%b expected 1/0", name, pulse, other);
    end
    xfr_complete_i = 1'b0;
    tick();
    vectors++;
    if (d_write_o !== 1'b0 || d_read_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_pulse_width: got wr=%b rd=%b expected 0/0", name, d_write_o, d_read_o);
    end
    stray = 1'b0;
    for (int i = 0; i < busy_len; i++) begin
      tick();
      if (d_write_o || d_read_o || dut.trans_done) stray = 1'b1;
    end
    vectors++;
    if (stray !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy_quiet: got activity=%b expected 0", name, stray);
    end
    xfr_complete_i = 1'b1;
    crc_ok_i = crc;
    int_status_rst_i = clr_at_done;
    tick();
    int_status_rst_i = 1'b0;
    vectors++;
    if (dut.trans_done !== 1'b1 || d_write_o !== 1'b0 || d_read_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: got td=%b wr=%b rd=%b expected 1/0/0", name, dut.trans_done, d_write_o, d_read_o);
    end
    n = 0;
    while ((dut.tx_cycle || dut.trans_done) && n < 5) begin
      tick();
      n++;
    end
    vectors++;
    if (int_status_o !== exp_status || dut.tx_cycle !== 1'b0 || dut.trans_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_status: got 0x%02h txc=%b td=%b expected 0x%02h txc=0 td=0",
               name, int_status_o, dut.tx_cycle, dut.trans_done, exp_status);
    end
    if (clear_after) clear_status(name);
  endtask

  task automatic test_write_read_ok;
    timeout_i = 24'd100;
    run_xfer(1, 1, 10, 0, 1, 5'h01, "write_ok");
    run_xfer(0, 1, 10, 0, 1, 5'h01, "read_ok");
  endtask

  task automatic test_crc_fail;
    timeout_i = 24'd100;
    run_xfer(1, 0, 10, 0, 1, 5'h0A, "write_crc");
    run_xfer(0, 0, 10, 0, 1, 5'h0A, "read_crc");
  endtask

  task automatic test_timeout_disabled;
    timeout_i = 24'd0;
    run_xfer(1, 1, 150, 0, 1, 5'h01, "write_noto");
    run_xfer(0, 1, 150, 0, 1, 5'h01, "read_noto");
  endtask

  // Second transfer completes in the same cycle as a status clear: the new bits remain.
  task automatic test_back_to_back;
    timeout_i = 24'd100;
    run_xfer(0, 1, 5, 0, 0, 5'h01, "b2b_first");
    run_xfer(1, 0, 5, 1, 1, 5'h0A, "b2b_set_wins");
  endtask

  task automatic test_rx_overflow;
    timeout_i = 24'd100;
    xfr_complete_i = 1'b1;
    start_rx_i = 1'b1;
    tick();
    start_rx_i = 1'b0;
    tick();
    xfr_complete_i = 1'b0;
    tick(); tick(); tick();
    rx_fifo_full_i = 1'b1;
    tick();
    rx_fifo_full_i = 1'b0;
    vectors++;
    if (d_write_o !== 1'b1 || d_read_o !== 1'b1 || dut.trans_done !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_stop: got wr=%b rd=%b td=%b expected 1/1/1", d_write_o, d_read_o, dut.trans_done);
    end
    tick();
    vectors++;
    if (d_write_o !== 1'b1 || d_read_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_stop_hold: got wr=%b rd=%b expected 1/1", d_write_o, d_read_o);
    end
    tick();
    vectors++;
    if (d_write_o !== 1'b0 || d_read_o !== 1'b0 || dut.trans_done !== 1'b0 || int_status_o !== 5'h12) begin
      miscompares++;
      $display("FAIL ovf_idle: got wr=%b rd=%b td=%b st=0x%02h expected 0/0/0 0x12",
               d_write_o, d_read_o, dut.trans_done, int_status_o);
    end
    xfr_complete_i = 1'b1;
    clear_status("ovf");
  endtask

  task automatic test_timeout(input bit is_tx, input string name);
    int n;
    timeout_i = 24'd100;
    xfr_complete_i = 1'b1;
    tx_fifo_empty_i = 1'b0;
    if (is_tx) start_tx_i = 1'b1; else start_rx_i = 1'b1;
    tick();
    start_tx_i = 1'b0; start_rx_i = 1'b0;
    tick();
    vectors++;
    if ((is_tx ? d_write_o : d_read_o) !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_start: got wr=%b rd=%b expected start pulse", name, d_write_o, d_read_o);
    end
    xfr_complete_i = 1'b0;
    n = 0;
    while (!(d_write_o && d_read_o) && n < 300) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== 101 || dut.trans_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles td=%b expected 101 cycles td=1", name, n, dut.trans_done);
    end
    tick(); tick();
    vectors++;
    if (int_status_o !== 5'h06 || d_write_o !== 1'b0 || d_read_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_status: got 0x%02h wr=%b rd=%b expected 0x06 0/0", name, int_status_o, d_write_o, d_read_o);
    end
    xfr_complete_i = 1'b1;
    clear_status(name);
  endtask

  task automatic test_reset_mid_transfer;
    timeout_i = 24'd100;
    xfr_complete_i = 1'b1;
    tx_fifo_empty_i = 1'b0;
    start_tx_i = 1'b1;
    tick();
    start_tx_i = 1'b0;
    tick();
    xfr_complete_i = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({d_write_o, d_read_o, int_status_o, dut.tx_cycle, dut.trans_done} !== 9'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got wr=%b rd=%b st=0x%02h txc=%b td=%b expected all 0",
               d_write_o, d_read_o, int_status_o, dut.tx_cycle, dut.trans_done);
    end
    xfr_complete_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read_ok();
    test_crc_fail();
    test_rx_overflow();
    test_timeout(1, "write_to");
    test_timeout(0, "read_to");
    test_timeout_disabled();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
